// File: rtl/axi_read_slave.sv
// axi_read_slave: AXI3-style read-only slave backed by an internal word memory.
//
// Accepts one read burst at a time (FIXED, INCR or WRAP) and streams its beats
// on the R channel, one per cycle while RREADY is high. The memory is preloaded
// through a backdoor word-write port and is never cleared by reset.
//
// Ports:
//   ACLK, ARESET                  clock, synchronous active-high reset
//   ARID/ARADDR/ARLEN/ARSIZE/
//   ARBURST/ARVALID -> ARREADY    read address channel (ARLOCK/ARCACHE/ARPROT ignored)
//   RID/RDATA/RRESP/RLAST/
//   RVALID <- RREADY              read data channel
//   mem_we/mem_waddr/mem_wdata    backdoor memory word write
//
// MemDepth must be at least 2.
module axi_read_slave #(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned MemDepth = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [3:0]          ARID,
  input  logic [BusWidth-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [1:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic [1:0]          ARLOCK,
  input  logic [3:0]          ARCACHE,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [3:0]          RID,
  output logic [BusWidth-1:0] RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic                mem_we,
  input  logic [7:0]          mem_waddr,
  input  logic [BusWidth-1:0] mem_wdata
);

  localparam int unsigned AW = $clog2(MemDepth);

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  state_t state, state_nxt;

  logic [BusWidth-1:0] mem [MemDepth];

  // Burst context latched at the AR handshake
  logic [3:0]          len_q;
  logic [1:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [BusWidth-1:0] addr_q;
  logic [3:0]          beat_q;

  // Next beat to be loaded into the R output registers
  logic                ar_hs;
  logic                load_beat;
  logic                finish;
  logic [BusWidth-1:0] beat_addr;
  logic                beat_err;
  logic                beat_last;
  logic [3:0]          beat_num;
  logic [BusWidth-1:0] beat_data;
  logic                start_err;

  logic [BusWidth-1:0] incr;
  logic [BusWidth-1:0] wrap_mask;
  logic [BusWidth-1:0] nxt_addr;

  logic unused_sideband;
  assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

  always_comb begin
    start_err = 1'b0;
    if (ARBURST == 2'b11)
      start_err = 1'b1;
    if (ARBURST == 2'b10 &&
        !(ARLEN == 4'd1 || ARLEN == 4'd3 || ARLEN == 4'd7 || ARLEN == 4'd15))
      start_err = 1'b1;
    if (ARADDR >= BusWidth'(MemDepth * 4))
      start_err = 1'b1;
  end

  // WRAP keeps the upper address bits fixed at the (len+1)*size boundary and
  // lets only the bits below it increment; the legal lengths make that span a
  // power of two, so a mask is sufficient.
  always_comb begin
    incr      = BusWidth'(1) << size_q;
    wrap_mask = ((BusWidth'(len_q) + BusWidth'(1)) << size_q) - BusWidth'(1);
    case (burst_q)
      2'b00:   nxt_addr = addr_q;
      2'b10:   nxt_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: nxt_addr = addr_q + incr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ARREADY   = 1'b0;
    ar_hs     = 1'b0;
    load_beat = 1'b0;
    finish    = 1'b0;
    beat_addr = addr_q;
    beat_err  = err_q;
    beat_num  = beat_q;
    beat_last = 1'b0;
    case (state)
      IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) begin
          ar_hs     = 1'b1;
          load_beat = 1'b1;
          beat_addr = ARADDR;
          beat_err  = start_err;
          beat_num  = '0;
          beat_last = (ARLEN == 4'd0);
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (RVALID && RREADY) begin
          if (RLAST) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            load_beat = 1'b1;
            beat_addr = nxt_addr;
            beat_num  = beat_q + 4'd1;
            beat_last = (beat_q + 4'd1 == len_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read happens before this cycle's backdoor write lands, so a beat loaded
  // alongside a write to the same word returns the old contents.
  always_comb begin
    if (beat_err)
      beat_data = '0;
    else
      beat_data = mem[AW'((beat_addr >> 2) % BusWidth'(MemDepth))];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ar_hs) begin
        RID     <= ARID;
        len_q   <= ARLEN;
        size_q  <= ARSIZE;
        burst_q <= ARBURST;
        err_q   <= start_err;
      end
      if (load_beat) begin
        addr_q <= beat_addr;
        beat_q <= beat_num;
        RDATA  <= beat_data;
        RRESP  <= beat_err ? 2'b10 : 2'b00;
        RLAST  <= beat_last;
        RVALID <= 1'b1;
      end else if (finish) begin
        RVALID <= 1'b0;
        RLAST  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we)
      mem[AW'(mem_waddr)] <= mem_wdata;
  end

endmodule

// File: tb/tb_axi_read_slave.sv
module tb_axi_read_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [1:0]  ARLOCK;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;

  axi_read_slave #(.BusWidth(32), .MemDepth(256)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned beats_taken = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push(input logic [3:0] id, input logic [31:0] data,
                      input logic [1:0] resp, input logic last);
    beat_t b;
    b.id = id; b.data = data; b.resp = resp; b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: every presented beat is checked against the queue head (so stalled
  // beats must stay unchanged); the head is retired only on a handshake.
  always @(negedge ACLK) begin
    if (!ARESET && RVALID) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {28'd0, RID, RDATA}, 64'hDEAD);
      end else begin
        chk("rid",    64'(RID),    64'(exp_q[0].id));
        chk("rdata",  64'(RDATA),  64'(exp_q[0].data));
        chk("rresp",  64'(RRESP),  64'(exp_q[0].resp));
        chk("rlast",  64'(RLAST),  64'(exp_q[0].last));
        chk("arready_in_data", 64'(ARREADY), 64'd0);
        if (RREADY) begin
          void'(exp_q.pop_front());
          beats_taken++;
        end
      end
    end
  end

  // Called at #1 after a rising edge; returns #1 after the handshake edge.
  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [1:0] size, input logic [1:0] burst);
    int unsigned n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin
      n++;
      @(negedge ACLK);
    end
    if (!ARREADY) begin
      chk("ar_timeout", 64'd0, 64'd1);
      ARVALID = 1'b0;
    end else begin
      @(posedge ACLK);
      #1;
      ARVALID = 1'b0;
      chk("rvalid_latency", 64'(RVALID), 64'd1);
    end
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (!(exp_q.size() == 0 && !RVALID) && n < 100) begin
      n++;
      @(posedge ACLK);
      #1;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle_arready"}, 64'(ARREADY), 64'd1);
  endtask

  initial begin
    ARESET = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    ARLOCK = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;

    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_arready", 64'(ARREADY), 64'd1);
    chk("rst_rvalid",  64'(RVALID),  64'd0);
    chk("rst_rlast",   64'(RLAST),   64'd0);
    chk("rst_rid",     64'(RID),     64'd0);
    chk("rst_rdata",   64'(RDATA),   64'd0);
    chk("rst_rresp",   64'(RRESP),   64'd0);
    ARESET = 1'b0;

    mem_we = 1'b1;
    for (int k = 0; k < 256; k++) begin
      mem_waddr = 8'(k);
      mem_wdata = 32'hA000_0000 + 32'(k);
      @(posedge ACLK);
      #1;
    end
    mem_we = 1'b0;

    // INCR 0x10, len 3, size 2
    push(4'd1, 32'hA000_0004, 2'b00, 1'b0);
    push(4'd1, 32'hA000_0005, 2'b00, 1'b0);
    push(4'd1, 32'hA000_0006, 2'b00, 1'b0);
    push(4'd1, 32'hA000_0007, 2'b00, 1'b1);
    ar(4'd1, 32'h10, 4'd3, 2'd2, 2'b01);
    drain("incr");

    // WRAP 0x38, len 3, size 2 -> words 14,15,12,13
    push(4'd2, 32'hA000_000E, 2'b00, 1'b0);
    push(4'd2, 32'hA000_000F, 2'b00, 1'b0);
    push(4'd2, 32'hA000_000C, 2'b00, 1'b0);
    push(4'd2, 32'hA000_000D, 2'b00, 1'b1);
    ar(4'd2, 32'h38, 4'd3, 2'd2, 2'b10);
    drain("wrap");

    // Backpressure: RREADY 1,0,0,1 over INCR len 1 at word 16
    push(4'd3, 32'hA000_0010, 2'b00, 1'b0);
    push(4'd3, 32'hA000_0011, 2'b00, 1'b1);
    beats_taken = 0;
    ar(4'd3, 32'h40, 4'd1, 2'd2, 2'b01);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    @(posedge ACLK); #1;
    chk("bp_stall_arready", 64'(ARREADY), 64'd0);
    @(posedge ACLK); #1;
    chk("bp_stall_rvalid", 64'(RVALID), 64'd1);
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    chk("bp_done_rvalid", 64'(RVALID), 64'd0);
    chk("bp_beats", 64'(beats_taken), 64'd2);
    drain("bp");

    // Error cases
    for (int i = 0; i < 3; i++) push(4'd4, 32'h0, 2'b10, i == 2);
    ar(4'd4, 32'h0, 4'd2, 2'd2, 2'b11);
    drain("err_burst");
    push(4'd6, 32'h0, 2'b10, 1'b1);
    ar(4'd6, 32'h400, 4'd0, 2'd2, 2'b01);
    drain("err_addr");
    for (int i = 0; i < 3; i++) push(4'd7, 32'h0, 2'b10, i == 2);
    ar(4'd7, 32'h0, 4'd2, 2'd2, 2'b10);
    drain("err_wraplen");

    // FIXED 0x20, len 2, ID 5
    for (int i = 0; i < 3; i++) push(4'd5, 32'hA000_0008, 2'b00, i == 2);
    ar(4'd5, 32'h20, 4'd2, 2'd2, 2'b00);
    drain("fixed");

    // Backdoor write in the handshake cycle: beat 0 old, beat 1 new
    push(4'd8, 32'hA000_0014, 2'b00, 1'b0);
    push(4'd8, 32'h1234_5678, 2'b00, 1'b1);
    mem_we = 1'b1; mem_waddr = 8'd20; mem_wdata = 32'h1234_5678;
    ar(4'd8, 32'h50, 4'd1, 2'd2, 2'b00);
    mem_we = 1'b0;
    drain("wr_collide");

    // Reset during beat 2 of INCR len 7
    for (int i = 0; i < 8; i++) push(4'd9, 32'hA000_0000 + 32'(i), 2'b00, i == 7);
    beats_taken = 0;
    ar(4'd9, 32'h0, 4'd7, 2'd2, 2'b01);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("rstmid_rvalid",  64'(RVALID),  64'd0);
    chk("rstmid_arready", 64'(ARREADY), 64'd1);
    chk("rstmid_rlast",   64'(RLAST),   64'd0);
    chk("rstmid_beats",   64'(beats_taken), 64'd2);
    chk("rstmid_pending", 64'(exp_q.size()), 64'd6);
    exp_q.delete();
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("rstmid_quiet", 64'(RVALID), 64'd0);
    push(4'd10, 32'hA000_0018, 2'b00, 1'b0);
    push(4'd10, 32'hA000_0019, 2'b00, 1'b1);
    ar(4'd10, 32'h60, 4'd1, 2'd2, 2'b01);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
AXI_READ_SLAVE -- requirements
Module: axi_read_slave

Interface
REQ-001 SHALL have parameter BusWidth, default 32, data and address width in bits.
REQ-002 SHALL have parameter MemDepth, default 256, number of BusWidth-bit words in internal memory.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ARID  input  4  transaction ID.
REQ-006 SHALL have port ARADDR  input  BusWidth  byte start address.
REQ-007 SHALL have port ARLEN  input  4  beats minus one.
REQ-008 SHALL have port ARSIZE  input  2  log2 bytes per beat.
REQ-009 SHALL have port ARBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 SHALL have ports ARLOCK(2), ARCACHE(4), ARPROT(3)  input  ignored.
REQ-011 SHALL have port ARVALID  input  1  / ARREADY  output  1  address handshake.
REQ-012 SHALL have port RID  output  4  / RDATA  output  BusWidth  / RRESP  output  2  / RLAST  output  1.
REQ-013 SHALL have port RVALID  output  1  / RREADY  input  1  data handshake.
REQ-014 SHALL have ports mem_we  input  1, mem_waddr  input  8, mem_wdata  input  BusWidth  (backdoor word write for preload).

Function
REQ-015 SHALL implement two states: IDLE (ARREADY=1, RVALID=0) and DATA (ARREADY=0).
REQ-016 SHALL, in IDLE on ARVALID&&ARREADY, latch ARID/ARADDR/ARLEN/ARSIZE/ARBURST, clear beat counter, move to DATA.
REQ-017 SHALL assert RVALID with beat 0 the cycle after the AR handshake (latency 1).
REQ-018 SHALL hold RID, RDATA, RRESP, RLAST stable while RVALID&&!RREADY.
REQ-019 SHALL, on each RVALID&&RREADY, load the next beat into the output registers and advance the beat counter, so back-to-back beats stream every cycle.
REQ-020 SHALL drive RLAST=1 exactly on beat ARLEN; the handshake on that beat SHALL return to IDLE with RVALID=0 and ARREADY=1 the next cycle.
REQ-021 SHALL make RID equal to the latched ARID for every beat.
REQ-022 SHALL return RDATA = mem[(addr>>2) mod MemDepth], the whole word containing the beat address.
REQ-023 SHALL compute the beat address as follows: FIXED = start address every beat; INCR = previous + (1<<ARSIZE).
REQ-024 SHALL compute WRAP beat addresses as INCR, but wrapped within a boundary aligned to (ARLEN+1)*(1<<ARSIZE) bytes.
REQ-025 SHALL return RRESP=2'b10 (SLVERR) and RDATA=0 on every beat when: ARBURST=11; WRAP with ARLEN not in {1,3,7,15}; or start address >= MemDepth*4.
REQ-026 SHALL otherwise return RRESP=2'b00, while still producing ARLEN+1 beats.
REQ-027 SHALL write mem[mem_waddr]<=mem_wdata when mem_we=1, in any state.
REQ-028 SHALL give a beat loaded in the same cycle as a write to that word the old data.
REQ-029 SHALL ignore ARVALID while in DATA.

Reset
REQ-030 SHALL, while ARESET=1 at a clock edge, set state=IDLE, ARREADY=1, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, beat counter=0.
REQ-031 SHALL, on reset mid-burst, abandon the burst with no further beats.
REQ-032 SHALL NOT clear memory contents on reset.

Verification
REQ-033 Bench SHALL cover INCR: preload mem[k]=0xA000_0000+k; AR addr 0x10, len 3, size 2 -> beats 0xA0000004..0xA0000007, RLAST on 4th, RRESP 00, RVALID 1 cycle after AR.
REQ-034 Bench SHALL cover WRAP: addr 0x38, len 3, size 2 -> words 14,15,12,13; RLAST on word 13.
REQ-035 Bench SHALL cover backpressure: RREADY toggling 1,0,0,1 over an INCR len 1 burst -> RDATA/RLAST/RID held during stalls, exactly 2 beats, ARREADY=0 until after last.
REQ-036 Bench SHALL cover errors: ARBURST=11 len 2 -> 3 beats RRESP 10, RDATA 0; addr 0x400 INCR -> SLVERR; WRAP len 2 -> SLVERR.
REQ-037 Bench SHALL cover reset: ARESET=1 during beat 2 of len 7 -> next cycle RVALID=0, ARREADY=1; new AR afterwards serviced normally; memory contents preserved.
REQ-038 Bench SHALL cover FIXED: addr 0x20, len 2, ID 5 -> three beats of mem[8], RID=5 throughout.
